// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush/redirect controller:
// FSM states, PC source selects and trap cause selects.
package rv_pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_MEM_WAIT   = 3'd1,
    ST_TRAP_FLUSH = 3'd2,
    ST_TRAP_ENTER = 3'd3,
    ST_MRET       = 3'd4
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ   = 2'b00;
  localparam logic [1:0] PC_SRC_BR    = 2'b01;
  localparam logic [1:0] PC_SRC_MTVEC = 2'b10;
  localparam logic [1:0] PC_SRC_MEPC  = 2'b11;

  localparam logic CAUSE_EXT   = 1'b0;
  localparam logic CAUSE_BUSTO = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory busy cycles and flags the bus timeout
// on the last permitted busy cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // A zero count means idle, so the flag can only fire during an active wait.
  assign timeout = busy && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (busy && (cnt != '0) && !timeout) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/redirect FSM for the 5-stage pipeline: load-use stall,
// data-memory wait with timeout, branch flush, trap entry and mret return.
module pipeline_sequencer
  import rv_pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_EX_memread,
  input  logic [4:0] ID_EX_rd,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       branch_taken,
  input  logic       mem_busy,
  input  logic       trap_req,
  input  logic       mret_req,
  output logic       pc_en,
  output logic       IF_ID_en,
  output logic       ID_EX_en,
  output logic       EX_MEM_en,
  output logic       MEM_WB_en,
  output logic       c_or_nop,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush,
  output logic [1:0] pc_src,
  output logic       trap_commit,
  output logic       trap_cause_sel
);

  state_t state, next_state;
  logic   cause, next_cause;
  logic   timeout;
  logic   load_use;
  logic   run_decode;
  logic   start_wait;

  assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

  // MEM_WAIT releases with zero latency: the RUN decode applies in the cycle busy drops.
  assign run_decode = (state == ST_RUN) || ((state == ST_MEM_WAIT) && !mem_busy);
  assign start_wait = run_decode && !trap_req && !mret_req && mem_busy;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start_wait),
    .busy   (mem_busy),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cause <= CAUSE_EXT;
    end else begin
      state <= next_state;
      cause <= next_cause;
    end
  end

  always_comb begin
    next_state = state;
    next_cause = cause;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if ((state == ST_MEM_WAIT) && mem_busy) begin
          if (timeout) begin
            next_state = ST_TRAP_FLUSH;
            next_cause = CAUSE_BUSTO;
          end
        end else if (trap_req) begin
          next_state = ST_TRAP_FLUSH;
          next_cause = CAUSE_EXT;
        end else if (mret_req) begin
          next_state = ST_MRET;
        end else if (mem_busy) begin
          next_state = ST_MEM_WAIT;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_TRAP_FLUSH: next_state = ST_TRAP_ENTER;
      ST_TRAP_ENTER: begin
        next_state = ST_RUN;
        next_cause = CAUSE_EXT;
      end
      ST_MRET:       next_state = ST_RUN;
      default:       next_state = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en          = 1'b0;
    IF_ID_en       = 1'b0;
    ID_EX_en       = 1'b0;
    EX_MEM_en      = 1'b0;
    MEM_WB_en      = 1'b0;
    c_or_nop       = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EX_flush    = 1'b0;
    EX_MEM_flush   = 1'b0;
    pc_src         = PC_SRC_SEQ;
    trap_commit    = 1'b0;
    trap_cause_sel = CAUSE_EXT;
    if (rst) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (run_decode) begin
      if (trap_req) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
      end else if (mret_req) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        pc_en       = 1'b1;
        pc_src      = PC_SRC_MEPC;
      end else if (mem_busy) begin
        pc_en = 1'b0;
      end else begin
        {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b11111;
        c_or_nop = 1'b1;
        if (branch_taken) begin
          pc_src      = PC_SRC_BR;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (load_use) begin
          pc_en    = 1'b0;
          IF_ID_en = 1'b0;
          c_or_nop = 1'b0;
        end
      end
    end else begin
      case (state)
        ST_TRAP_FLUSH: begin
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
        end
        ST_TRAP_ENTER: begin
          trap_commit    = 1'b1;
          trap_cause_sel = cause;
          pc_en          = 1'b1;
          pc_src         = PC_SRC_MTVEC;
        end
        ST_MRET: begin
          {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b11111;
          c_or_nop = 1'b1;
        end
        default: pc_en = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a short memory timeout.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ID_EX_memread = 1'b0;
  logic [4:0] ID_EX_rd = 5'd0;
  logic [4:0] IF_ID_rs1 = 5'd0;
  logic [4:0] IF_ID_rs2 = 5'd0;
  logic       branch_taken = 1'b0;
  logic       mem_busy = 1'b0;
  logic       trap_req = 1'b0;
  logic       mret_req = 1'b0;
  logic       pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic       c_or_nop;
  logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [1:0] pc_src;
  logic       trap_commit, trap_cause_sel;

  int checks = 0;
  int errors = 0;

  logic [4:0] en_v;
  logic [2:0] fl_v;
  logic [9:0] ctl;
  assign en_v = {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en};
  assign fl_v = {IF_ID_flush, ID_EX_flush, EX_MEM_flush};
  assign ctl  = {en_v, fl_v, pc_src};

  pipeline_sequencer #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .trap_req(trap_req), .mret_req(mret_req),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en), .c_or_nop(c_or_nop),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .pc_src(pc_src), .trap_commit(trap_commit), .trap_cause_sel(trap_cause_sel)
  );

  always #5 clk = ~clk;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (ctl !== {5'b00000, 3'b111, 2'b00}) begin
      errors++; $display("FAIL reset_ctl act=%b exp=%b", ctl, {5'b00000, 3'b111, 2'b00});
    end
    checks++;
    if ({c_or_nop, trap_commit} !== 2'b00) begin
      errors++; $display("FAIL reset_cnop_commit act=%b exp=00", {c_or_nop, trap_commit});
    end
    next_cyc;
    rst = 1'b0;
    #1;
    checks++;
    if ({ctl, c_or_nop} !== {5'b11111, 3'b000, 2'b00, 1'b1}) begin
      errors++; $display("FAIL run_idle act=%b exp=%b", {ctl, c_or_nop}, {5'b11111, 3'b000, 2'b00, 1'b1});
    end
  endtask

  task automatic test_load_use;
    next_cyc;
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd5;
    #1;
    checks++;
    if ({ctl, c_or_nop} !== {5'b00111, 3'b000, 2'b00, 1'b0}) begin
      errors++; $display("FAIL lu_rs2 act=%b exp=%b", {ctl, c_or_nop}, {5'b00111, 3'b000, 2'b00, 1'b0});
    end
    next_cyc;
    ID_EX_memread = 1'b0;
    #1;
    checks++;
    if ({en_v, c_or_nop} !== 6'b111111) begin
      errors++; $display("FAIL lu_after act=%b exp=111111", {en_v, c_or_nop});
    end
    next_cyc;
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd7; IF_ID_rs2 = 5'd1;
    #1;
    checks++;
    if ({en_v, c_or_nop} !== 6'b001110) begin
      errors++; $display("FAIL lu_rs1 act=%b exp=001110", {en_v, c_or_nop});
    end
    next_cyc;
    ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;
    #1;
    checks++;
    if ({en_v, c_or_nop} !== 6'b111111) begin
      errors++; $display("FAIL lu_x0 act=%b exp=111111", {en_v, c_or_nop});
    end
    next_cyc;
    ID_EX_memread = 1'b0; ID_EX_rd = 5'd9; IF_ID_rs1 = 5'd9;
    #1;
    checks++;
    if ({en_v, c_or_nop} !== 6'b111111) begin
      errors++; $display("FAIL lu_not_load act=%b exp=111111", {en_v, c_or_nop});
    end
    ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0;
  endtask

  task automatic test_branch;
    next_cyc;
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== {5'b11111, 3'b110, 2'b01}) begin
      errors++; $display("FAIL br_taken act=%b exp=%b", ctl, {5'b11111, 3'b110, 2'b01});
    end
    next_cyc;
    branch_taken = 1'b0;
    #1;
    checks++;
    if (ctl !== {5'b11111, 3'b000, 2'b00}) begin
      errors++; $display("FAIL br_after act=%b exp=%b", ctl, {5'b11111, 3'b000, 2'b00});
    end
  endtask

  task automatic test_mem_wait;
    for (int i = 0; i < 3; i++) begin
      next_cyc;
      mem_busy = 1'b1;
      trap_req = (i == 1);
      branch_taken = (i == 1);
      #1;
      checks++;
      if ({ctl, trap_commit} !== {5'b00000, 3'b000, 2'b00, 1'b0}) begin
        errors++; $display("FAIL wait_cyc%0d act=%b exp=%b", i, {ctl, trap_commit}, {5'b00000, 3'b000, 2'b00, 1'b0});
      end
    end
    next_cyc;
    mem_busy = 1'b0; trap_req = 1'b0; branch_taken = 1'b0;
    #1;
    checks++;
    if ({ctl, c_or_nop, trap_commit} !== {5'b11111, 3'b000, 2'b00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wait_release act=%b exp=%b", {ctl, c_or_nop, trap_commit}, {5'b11111, 3'b000, 2'b00, 1'b1, 1'b0});
    end
    next_cyc;
    checks++;
    if ({ctl, trap_commit} !== {5'b11111, 3'b000, 2'b00, 1'b0}) begin
      errors++; $display("FAIL wait_no_trap act=%b exp=%b", {ctl, trap_commit}, {5'b11111, 3'b000, 2'b00, 1'b0});
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 8; i++) begin
      next_cyc;
      mem_busy = 1'b1;
      #1;
      checks++;
      if ({ctl, trap_commit} !== {5'b00000, 3'b000, 2'b00, 1'b0}) begin
        errors++; $display("FAIL to_busy%0d act=%b exp=%b", i, {ctl, trap_commit}, {5'b00000, 3'b000, 2'b00, 1'b0});
      end
    end
    next_cyc;
    #1;
    checks++;
    if ({ctl, trap_commit} !== {5'b00000, 3'b111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL to_flush act=%b exp=%b", {ctl, trap_commit}, {5'b00000, 3'b111, 2'b00, 1'b0});
    end
    next_cyc;
    mem_busy = 1'b0;
    #1;
    checks++;
    if ({ctl, trap_commit, trap_cause_sel} !== {5'b10000, 3'b000, 2'b10, 1'b1, 1'b1}) begin
      errors++; $display("FAIL to_commit act=%b exp=%b", {ctl, trap_commit, trap_cause_sel}, {5'b10000, 3'b000, 2'b10, 1'b1, 1'b1});
    end
    next_cyc;
    checks++;
    if ({ctl, trap_commit} !== {5'b11111, 3'b000, 2'b00, 1'b0}) begin
      errors++; $display("FAIL to_back_run act=%b exp=%b", {ctl, trap_commit}, {5'b11111, 3'b000, 2'b00, 1'b0});
    end
  endtask

  task automatic test_trap_vs_mret;
    next_cyc;
    trap_req = 1'b1; mret_req = 1'b1;
    #1;
    checks++;
    if ({ctl, trap_commit} !== {5'b00000, 3'b111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL tm_req act=%b exp=%b", {ctl, trap_commit}, {5'b00000, 3'b111, 2'b00, 1'b0});
    end
    next_cyc;
    trap_req = 1'b0; mret_req = 1'b0;
    #1;
    checks++;
    if ({ctl, trap_commit} !== {5'b00000, 3'b111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL tm_flush act=%b exp=%b", {ctl, trap_commit}, {5'b00000, 3'b111, 2'b00, 1'b0});
    end
    next_cyc;
    checks++;
    if ({ctl, trap_commit, trap_cause_sel} !== {5'b10000, 3'b000, 2'b10, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tm_commit act=%b exp=%b", {ctl, trap_commit, trap_cause_sel}, {5'b10000, 3'b000, 2'b10, 1'b1, 1'b0});
    end
    next_cyc;
    checks++;
    if ({ctl, trap_commit} !== {5'b11111, 3'b000, 2'b00, 1'b0}) begin
      errors++; $display("FAIL tm_back_run act=%b exp=%b", {ctl, trap_commit}, {5'b11111, 3'b000, 2'b00, 1'b0});
    end
  endtask

  task automatic test_mret;
    next_cyc;
    mret_req = 1'b1;
    #1;
    checks++;
    if (pc_src !== 2'b11 || pc_en !== 1'b1 || IF_ID_flush !== 1'b1 || ID_EX_flush !== 1'b1) begin
      errors++; $display("FAIL mret_redirect act=%b exp=pc_en1 flush11x pc_src11", ctl);
    end
    next_cyc;
    #1;
    checks++;
    if ({ctl, c_or_nop} !== {5'b11111, 3'b000, 2'b00, 1'b1}) begin
      errors++; $display("FAIL mret_slot act=%b exp=%b", {ctl, c_or_nop}, {5'b11111, 3'b000, 2'b00, 1'b1});
    end
    next_cyc;
    mret_req = 1'b0;
    #1;
    checks++;
    if (ctl !== {5'b11111, 3'b000, 2'b00}) begin
      errors++; $display("FAIL mret_after act=%b exp=%b", ctl, {5'b11111, 3'b000, 2'b00});
    end
  endtask

  task automatic test_reset_in_trap;
    int commits;
    commits = 0;
    next_cyc;
    trap_req = 1'b1;
    #1;
    next_cyc;
    trap_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({ctl, trap_commit} !== {5'b00000, 3'b111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL rst_in_flush act=%b exp=%b", {ctl, trap_commit}, {5'b00000, 3'b111, 2'b00, 1'b0});
    end
    next_cyc;
    commits += int'(trap_commit);
    checks++;
    if (fl_v !== 3'b111) begin
      errors++; $display("FAIL rst_hold_flush act=%b exp=111", fl_v);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ctl, c_or_nop} !== {5'b11111, 3'b000, 2'b00, 1'b1}) begin
      errors++; $display("FAIL rst_release_run act=%b exp=%b", {ctl, c_or_nop}, {5'b11111, 3'b000, 2'b00, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      commits += int'(trap_commit);
      next_cyc;
    end
    checks++;
    if (commits !== 0) begin
      errors++; $display("FAIL rst_no_commit act=%0d exp=0", commits);
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_mem_wait;
    test_timeout;
    test_trap_vs_mret;
    test_mret;
    test_reset_in_trap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
